// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: FSM states, default reset PC and opcode constants.
// The FAULT state exists only when IFU_ALIGN_CHECK_EN is defined.
package instr_fetch_unit_pkg;

    localparam int unsigned IFU_XLEN     = 32;
    localparam logic [31:0] IFU_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
`ifdef IFU_ALIGN_CHECK_EN
        , ST_FAULT = 2'd3
`endif
    } ifu_state_e;

    localparam logic [6:0]  OP_R = 7'b0110011;
    localparam logic [6:0]  OP_S = 7'b0100011;
    localparam logic [6:0]  OP_L = 7'b0000011;
    localparam logic [6:0]  OP_B = 7'b1100011;
    localparam logic [31:0] NOP  = 32'h0000_0013;

    function automatic logic is_word_aligned(input logic [1:0] low_bits);
        return low_bits == 2'b00;
    endfunction

endpackage

// File: rtl/instr_fetch_unit_pc_gen.sv
// Program counter for the fetch unit: +4 sequential advance and redirect mux.
// With IFU_ALIGN_CHECK_EN a misaligned redirect target is flagged; otherwise its low bits are cleared.
module instr_fetch_unit_pc_gen
    import instr_fetch_unit_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
)(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            advance_i,
    input  logic            redirect_valid_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic [XLEN-1:0] pc_o
`ifdef IFU_ALIGN_CHECK_EN
    ,
    output logic            misaligned_o
`endif
);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;
    logic [XLEN-1:0] target;

`ifdef IFU_ALIGN_CHECK_EN
    assign target       = redirect_pc_i;
    assign misaligned_o = !is_word_aligned(redirect_pc_i[1:0]);
`else
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);
    assign target = redirect_pc_i & ALIGN_MASK;
`endif

    // Redirect wins over the sequential step; the add wraps modulo 2^XLEN.
    always_comb begin
        pc_d = pc_q;
        if (redirect_valid_i) begin
            pc_d = target;
        end else if (advance_i) begin
            pc_d = pc_q + XLEN'(4);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: one outstanding word read, valid/ready hand-off to decode, branch redirect.
// Define IFU_ALIGN_CHECK_EN to trap misaligned redirect targets in a sticky FAULT state.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int              XLEN     = IFU_XLEN,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(IFU_RESET_PC)
)(
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    output logic [6:0]      opcode,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            fetch_fault
);

    logic [XLEN-1:0] pc;
    ifu_state_e      state_q;
    logic            drop_q;
    logic            instr_valid_q;
    logic [XLEN-1:0] instr_q;
    logic [XLEN-1:0] instr_pc_q;
    logic            accept;
    logic            advance;
`ifdef IFU_ALIGN_CHECK_EN
    logic            misaligned;
    logic            fault_q;
`endif

    assign accept  = imem_req_valid && imem_req_ready;
    assign advance = (state_q == ST_WAIT) && imem_rsp_valid && !drop_q && !redirect_valid;

    instr_fetch_unit_pc_gen #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC)
    ) u_pc_gen (
        .clk              (clk),
        .rst_n            (rst_n),
        .advance_i        (advance),
        .redirect_valid_i (redirect_valid),
        .redirect_pc_i    (redirect_pc),
        .pc_o             (pc)
`ifdef IFU_ALIGN_CHECK_EN
        ,
        .misaligned_o     (misaligned)
`endif
    );

    // drop_q marks an in-flight read made stale by a redirect; its response is swallowed in WAIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_REQ;
            drop_q        <= 1'b0;
            instr_valid_q <= 1'b0;
            instr_q       <= '0;
            instr_pc_q    <= '0;
`ifdef IFU_ALIGN_CHECK_EN
            fault_q       <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_REQ: begin
                    if (accept) begin
                        state_q <= ST_WAIT;
                        drop_q  <= redirect_valid;
                    end
                end
                ST_WAIT: begin
                    if (imem_rsp_valid) begin
                        drop_q <= 1'b0;
                        if (drop_q || redirect_valid) begin
                            state_q <= ST_REQ;
                        end else begin
                            state_q       <= ST_HOLD;
                            instr_q       <= imem_rsp_data;
                            instr_pc_q    <= pc;
                            instr_valid_q <= 1'b1;
                        end
                    end else if (redirect_valid) begin
                        drop_q <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (redirect_valid || instr_ready) begin
                        state_q       <= ST_REQ;
                        instr_valid_q <= 1'b0;
                    end
                end
`ifdef IFU_ALIGN_CHECK_EN
                ST_FAULT: begin
                    state_q <= ST_FAULT;
                end
`endif
                default: begin
                    state_q <= ST_REQ;
                end
            endcase
`ifdef IFU_ALIGN_CHECK_EN
            if (redirect_valid && misaligned && (state_q != ST_FAULT)) begin
                state_q       <= ST_FAULT;
                fault_q       <= 1'b1;
                instr_valid_q <= 1'b0;
                drop_q        <= 1'b0;
            end
`endif
        end
    end

    // Gated by rst_n so no request is visible while reset is held, even though state_q already reads REQ.
    assign imem_req_valid = rst_n && (state_q == ST_REQ);
    assign imem_req_addr  = pc;
    assign instr_valid    = instr_valid_q;
    assign instr          = instr_q;
    assign instr_pc       = instr_pc_q;
    assign opcode         = instr_q[6:0];

`ifdef IFU_ALIGN_CHECK_EN
    assign fetch_fault = fault_q;
`else
    assign fetch_fault = 1'b0;
`endif

    a_req_aligned: assert property (@(posedge clk) disable iff (!rst_n)
        imem_req_valid |-> (imem_req_addr[1:0] == 2'b00));

    a_hold_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (instr_valid && !instr_ready && !redirect_valid)
            |=> (instr_valid && $stable(instr) && $stable(instr_pc)));

    a_single_outstanding: assert property (@(posedge clk) disable iff (!rst_n)
        instr_valid |-> !imem_req_valid);

`ifdef IFU_ALIGN_CHECK_EN
    a_fault_sticky: assert property (@(posedge clk) disable iff (!rst_n)
        fetch_fault |=> (fetch_fault && !imem_req_valid && !instr_valid));
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a transaction-level model and a delivered-PC scoreboard.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [6:0]  opcode;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fetch_fault;

    instr_fetch_unit #(
        .XLEN     (32),
        .RESET_PC (32'h0)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .opcode         (opcode),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fetch_fault    (fetch_fault)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // stimulus knobs (percentages / latency range in extra cycles)
    int pReady = 100, pRedir = 0, pIready = 100, pMisalign = 0, pSpur = 0;
    int latMin = 0, latMax = 0;
    bit          forceRedir = 1'b0;
    logic [31:0] forceRpc   = 32'h0;

    // memory environment: at most one read in flight
    bit          memBusy = 1'b0;
    int          memCnt  = 0;
    logic [31:0] memAddr = 32'h0;

    // transaction-level model of what the fetch unit must show
    logic [31:0] mPc = 32'h0;
    bit          mOut = 1'b0, mDiscard = 1'b0, mPresent = 1'b0, mFault = 1'b0;
    logic [31:0] mInstr = 32'h0, mInstrPc = 32'h0;
    logic [31:0] expNext = 32'h0;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        if (a == 32'h0000_0000) return 32'h0000_0033;
        if (a == 32'h0000_0004) return 32'h0000_A023;
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compareModel();
        bit expReq;
        expReq = !mFault && !mOut && !mPresent;
        checkOutput("req_valid", 32'(imem_req_valid), 32'(expReq));
        if (expReq) checkOutput("req_addr", imem_req_addr, mPc);
        checkOutput("instr_valid", 32'(instr_valid), 32'(mPresent));
        if (mPresent) begin
            checkOutput("instr", instr, mInstr);
            checkOutput("instr_pc", instr_pc, mInstrPc);
            checkOutput("opcode", 32'(opcode), 32'(mInstr[6:0]));
        end
        checkOutput("fetch_fault", 32'(fetch_fault), 32'(mFault));
    endtask

    // One clock cycle: check outputs, drive inputs, advance the model, then move to the next falling edge.
    task automatic applyStimulus();
        bit          accepted;
        bit          faultNow;
        logic [31:0] target;
        compareModel();

        imem_rsp_valid = 1'b0;
        imem_rsp_data  = $urandom;
        if (memBusy) begin
            if (memCnt == 0) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = memWord(memAddr);
                memBusy        = 1'b0;
            end else begin
                memCnt--;
            end
        end else if ($urandom_range(0, 99) < pSpur) begin
            imem_rsp_valid = 1'b1;
        end
        imem_req_ready = !memBusy && ($urandom_range(0, 99) < pReady);

        redirect_valid = 1'b0;
        redirect_pc    = $urandom;
        if (forceRedir) begin
            redirect_valid = 1'b1;
            redirect_pc    = forceRpc;
            forceRedir     = 1'b0;
        end else if ($urandom_range(0, 99) < pRedir) begin
            redirect_valid = 1'b1;
            redirect_pc    = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
            if ($urandom_range(0, 99) < pMisalign) redirect_pc[1:0] = 2'($urandom_range(1, 3));
        end
        instr_ready = ($urandom_range(0, 99) < pIready);

        // architectural view: delivered PCs run sequentially except where a redirect intervenes
        if (instr_valid && instr_ready && !redirect_valid) begin
            checkOutput("deliver_pc", instr_pc, expNext);
            checkOutput("deliver_instr", instr, memWord(expNext));
            expNext = expNext + 32'd4;
        end

        accepted = !mFault && !mOut && !mPresent && imem_req_ready;
        faultNow = 1'b0;
`ifdef IFU_ALIGN_CHECK_EN
        faultNow = redirect_valid && (redirect_pc[1:0] != 2'b00);
`endif
        target = redirect_pc & 32'hFFFF_FFFC;
        if (mFault) begin
            mOut = 1'b0;
        end else if (faultNow) begin
            mFault = 1'b1; mPresent = 1'b0; mOut = 1'b0; mDiscard = 1'b0;
        end else if (redirect_valid) begin
            if (mPresent) begin
                mPresent = 1'b0;
            end else if (mOut) begin
                if (imem_rsp_valid) begin mOut = 1'b0; mDiscard = 1'b0; end
                else mDiscard = 1'b1;
            end else if (accepted) begin
                mOut = 1'b1; mDiscard = 1'b1;
            end
            mPc     = target;
            expNext = target;
        end else if (mPresent) begin
            if (instr_ready) mPresent = 1'b0;
        end else if (mOut) begin
            if (imem_rsp_valid) begin
                mOut = 1'b0;
                if (!mDiscard) begin
                    mPresent = 1'b1; mInstr = memWord(mPc); mInstrPc = mPc; mPc = mPc + 32'd4;
                end
                mDiscard = 1'b0;
            end
        end else if (accepted) begin
            mOut = 1'b1;
        end

        if (imem_req_valid && imem_req_ready) begin
            memBusy = 1'b1;
            memAddr = imem_req_addr;
            memCnt  = $urandom_range(latMin, latMax);
        end
        @(negedge clk);
    endtask

    // Called on a falling edge; leaves the bench at the falling edge where reset is released.
    task automatic applyReset(input bit flushMem);
        rst_n          = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        redirect_valid = 1'b0;
        instr_ready    = 1'b0;
        #1;
        checkOutput("rst_req_valid", 32'(imem_req_valid), 32'h0);
        checkOutput("rst_instr_valid", 32'(instr_valid), 32'h0);
        checkOutput("rst_instr", instr, 32'h0);
        checkOutput("rst_instr_pc", instr_pc, 32'h0);
        checkOutput("rst_fault", 32'(fetch_fault), 32'h0);
        mPc = 32'h0; mOut = 1'b0; mDiscard = 1'b0; mPresent = 1'b0; mFault = 1'b0;
        mInstr = 32'h0; mInstrPc = 32'h0; expNext = 32'h0;
        if (flushMem) memBusy = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("post_rst_req_valid", 32'(imem_req_valid), 32'h1);
        checkOutput("post_rst_addr", imem_req_addr, 32'h0);
    endtask

    task automatic setKnobs(input int rdy, input int irdy, input int lmin, input int lmax);
        pReady = rdy; pIready = irdy; latMin = lmin; latMax = lmax;
        pRedir = 0; pMisalign = 0; pSpur = 0;
    endtask

    initial begin
        rst_n = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
        redirect_valid = 1'b0; redirect_pc = 32'h0; instr_ready = 1'b0;
        @(negedge clk);

        // reset while a read is in flight; its late response must be ignored
        applyReset(1'b1);
        setKnobs(100, 100, 4, 4);
        repeat (2) applyStimulus();
        applyReset(1'b0);
        setKnobs(100, 100, 0, 0);
        repeat (10) applyStimulus();

        // two fetches, 1-cycle memory, decode stalls 5 cycles on the first
        applyReset(1'b1);
        setKnobs(100, 0, 0, 0);
        repeat (2) applyStimulus();
        for (int i = 0; i < 5; i++) begin
            checkOutput("hold_valid", 32'(instr_valid), 32'h1);
            checkOutput("hold_instr", instr, 32'h0000_0033);
            checkOutput("hold_pc", instr_pc, 32'h0);
            checkOutput("hold_no_req", 32'(imem_req_valid), 32'h0);
            applyStimulus();
        end
        pIready = 100;
        checkOutput("first_opcode", 32'(opcode), 32'(7'b0110011));
        applyStimulus();
        checkOutput("second_req_addr", imem_req_addr, 32'h4);
        checkOutput("gap_valid_a", 32'(instr_valid), 32'h0);
        applyStimulus();
        checkOutput("gap_valid_b", 32'(instr_valid), 32'h0);
        applyStimulus();
        checkOutput("second_valid", 32'(instr_valid), 32'h1);
        checkOutput("second_opcode", 32'(opcode), 32'(7'b0100011));
        checkOutput("second_pc", instr_pc, 32'h4);
        repeat (3) applyStimulus();

        // redirect while waiting: stale response dropped, refetch from target
        applyReset(1'b1);
        setKnobs(100, 100, 2, 2);
        applyStimulus();
        forceRedir = 1'b1; forceRpc = 32'h100;
        applyStimulus();
        checkOutput("wait_redir_valid_a", 32'(instr_valid), 32'h0);
        applyStimulus();
        checkOutput("wait_redir_valid_b", 32'(instr_valid), 32'h0);
        applyStimulus();
        checkOutput("wait_redir_valid_c", 32'(instr_valid), 32'h0);
        checkOutput("wait_redir_req", 32'(imem_req_valid), 32'h1);
        checkOutput("wait_redir_addr", imem_req_addr, 32'h100);
        repeat (6) applyStimulus();

        // redirect while holding, with decode ready in the same cycle
        applyReset(1'b1);
        setKnobs(100, 100, 0, 0);
        repeat (2) applyStimulus();
        forceRedir = 1'b1; forceRpc = 32'h100;
        applyStimulus();
        checkOutput("hold_redir_valid", 32'(instr_valid), 32'h0);
        checkOutput("hold_redir_addr", imem_req_addr, 32'h100);
        repeat (6) applyStimulus();

        // misaligned redirect target
        applyReset(1'b1);
        setKnobs(0, 100, 0, 0);
        forceRedir = 1'b1; forceRpc = 32'h102;
        applyStimulus();
        pReady = 100;
`ifdef IFU_ALIGN_CHECK_EN
        for (int i = 0; i < 3; i++) begin
            checkOutput("fault_flag", 32'(fetch_fault), 32'h1);
            checkOutput("fault_no_req", 32'(imem_req_valid), 32'h0);
            applyStimulus();
        end
`else
        checkOutput("misalign_req", 32'(imem_req_valid), 32'h1);
        checkOutput("misalign_addr", imem_req_addr, 32'h100);
        repeat (4) applyStimulus();
`endif

        // PC wraps from the top of the address space to zero
        applyReset(1'b1);
        setKnobs(0, 100, 0, 0);
        forceRedir = 1'b1; forceRpc = 32'hFFFF_FFFC;
        applyStimulus();
        pReady = 100;
        checkOutput("wrap_top_addr", imem_req_addr, 32'hFFFF_FFFC);
        repeat (3) applyStimulus();
        checkOutput("wrap_req", 32'(imem_req_valid), 32'h1);
        checkOutput("wrap_zero_addr", imem_req_addr, 32'h0);
        repeat (4) applyStimulus();

        // randomized segments, each entered through a reset at an arbitrary point
        for (int seg = 0; seg < 6; seg++) begin
            applyReset(seg[0]);
            pReady    = $urandom_range(30, 100);
            pIready   = $urandom_range(30, 100);
            pRedir    = $urandom_range(0, 15);
            pMisalign = (seg == 5) ? 5 : 0;
            pSpur     = $urandom_range(0, 20);
            latMin    = 0;
            latMax    = $urandom_range(0, 3);
            repeat (1500) applyStimulus();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
